// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache with block-level memory handshake.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache_controller #(
  parameter int unsigned LINES = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
`ifdef DCACHE_STATS_EN
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
`endif
  input  logic         mem_busywait
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t state, next_state;

  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags   [LINES];
  logic [127:0]     blocks [LINES];
  logic [127:0]     fill_buffer;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       offset;
  logic             request, hit, write_hit;
  logic [127:0]     cur_block;
  logic             unused;

  assign idx       = address[4 +: IDX_W];
  assign tag       = address[31 -: TAG_W];
  assign offset    = address[3:2];
  assign unused    = &{1'b0, address[1:0]};
  assign request   = read || write;
  assign hit       = valid[idx] && (tags[idx] == tag);
  assign cur_block = blocks[idx];
  assign write_hit = (state == IDLE) && hit && write;
  assign busywait  = request && !((state == IDLE) && hit);
  // A combined read+write is a store, so it does not drive load data.
  assign readdata  = ((state == IDLE) && hit && read && !write)
                     ? cur_block[{offset, 5'd0} +: 32] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (request && !hit)
          next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tags[idx], idx};
        mem_writedata = cur_block;
        if (!mem_busywait) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = address[31:4];
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Line storage is not reset; cleared valid bits make stale contents unreachable.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      blocks[idx] <= fill_buffer;
      tags[idx]   <= tag;
    end else if (write_hit) begin
      blocks[idx][{offset, 5'd0} +: 32] <= writedata;
    end
    if ((state == ALLOCATE) && !mem_busywait) fill_buffer <= mem_readdata;
  end

`ifdef DCACHE_STATS_EN
  // refill_pending marks the re-presented request after a refill so its hit is not counted.
  logic refill_pending;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count      <= '0;
      miss_count     <= '0;
      refill_pending <= 1'b0;
    end else if ((state == IDLE) && request) begin
      if (hit) begin
        if (!refill_pending) hit_count <= hit_count + 32'd1;
        refill_pending <= 1'b0;
      end else begin
        miss_count     <= miss_count + 32'd1;
        refill_pending <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a behavioural block memory.
module tb_dcache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         read, write;
  logic [31:0]  address, writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  dcache_controller #(.LINES(8)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata),
`ifdef DCACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  // Memory model: unwritten block a holds byte n = {a[3:0], n}, i.e. the low byte address.
  logic [127:0] mem_store [logic [27:0]];
  int unsigned  mem_cnt = 0;

  function automatic logic [127:0] mem_block(input logic [27:0] a);
    logic [127:0] b;
    if (mem_store.exists(a)) return mem_store[a];
    for (int n = 0; n < 16; n++) b[n*8 +: 8] = {a[3:0], 4'(n)};
    return b;
  endfunction

  initial begin
    mem_busywait = 1'b0;
    mem_readdata = '0;
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap++;
    if (mem_read || mem_write) begin
      if (mem_cnt < 2) begin
        mem_busywait = 1'b1;
        mem_cnt++;
      end else begin
        mem_busywait = 1'b0;
        mem_cnt = 0;
        if (mem_read)  mem_readdata = mem_block(mem_address);
        if (mem_write) mem_store[mem_address] = mem_writedata;
      end
    end else begin
      mem_busywait = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    read = rd; write = wr; address = a; writedata = d;
  endtask

  task automatic wait_ready(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busywait) break;
    end
    check({name, "_ready"}, 128'(i < 40), 128'(1));
  endtask

  task automatic wait_mem_read(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_read) break;
    end
    check({name, "_mem_read_seen"}, 128'(i < 40), 128'(1));
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_busy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"wr_hit_108", 1'b0, 1'b1, 32'h108, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{"rd_hit_108", 1'b1, 1'b0, 32'h108, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{"rd_hit_100", 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h03020100};
    vecs[3] = '{"rd_hit_10c", 1'b1, 1'b0, 32'h10F, 32'h0, 1'b0, 32'h0F0E0D0C};
    vecs[4] = '{"no_request", 1'b0, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0};
    vecs[5] = '{"rd_hit_104", 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h07060504};
    vecs[6] = '{"rd_other_line_miss", 1'b1, 1'b0, 32'h114, 32'h0, 1'b1, 32'h0};

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busywait", 128'(busywait), 128'(0));
    check("reset_mem_read", 128'(mem_read), 128'(0));
    check("reset_mem_write", 128'(mem_write), 128'(0));
    check("reset_readdata", 128'(readdata), 128'(0));
    @(negedge clock) reset = 1'b0;

    // Cold read miss
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h104, 32'h0);
    #1 check("cold_busy_same_cycle", 128'(busywait), 128'(1));
    @(posedge clock); #1;
    check("cold_mem_read", 128'(mem_read), 128'(1));
    check("cold_mem_write", 128'(mem_write), 128'(0));
    check("cold_mem_address", 128'(mem_address), 128'(28'h0000010));
    wait_ready("cold");
    check("cold_readdata", 128'(readdata), 128'(32'h07060504));

    // Hit vectors on line 0 (tag 2); the last one targets an empty line
    foreach (vecs[i]) begin
      @(posedge clock); #1;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      #1;
      check({vecs[i].name, "_busywait"}, 128'(busywait), 128'(vecs[i].exp_busy));
      check({vecs[i].name, "_readdata"}, 128'(readdata), 128'(vecs[i].exp_rdata));
      check({vecs[i].name, "_mem_idle"}, 128'({mem_read, mem_write}), 128'(0));
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("miss_withdrawn_mem_idle", 128'({mem_read, mem_write}), 128'(0));

    // Dirty eviction of line 0
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h184, 32'h0);
    #1 check("evict_busy", 128'(busywait), 128'(1));
    @(posedge clock); #1;
    check("evict_mem_write", 128'(mem_write), 128'(1));
    check("evict_mem_read_off", 128'(mem_read), 128'(0));
    check("evict_wb_address", 128'(mem_address), 128'(28'h0000010));
    check("evict_wb_word2", 128'(mem_writedata[95:64]), 128'(32'hDEADBEEF));
    check("evict_wb_block", mem_writedata, 128'h0F0E0D0C_DEADBEEF_07060504_03020100);
    wait_mem_read("evict");
    check("evict_fetch_address", 128'(mem_address), 128'(28'h0000018));
    check("evict_fetch_mem_write_off", 128'(mem_write), 128'(0));
    wait_ready("evict");
    check("evict_readdata", 128'(readdata), 128'(32'h87868584));

    // Reset mid-ALLOCATE (line 0 is clean, so this goes straight to fetch)
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h284, 32'h0);
    @(posedge clock); #1;
    check("abort_mem_read_before", 128'(mem_read), 128'(1));
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("abort_mem_read", 128'(mem_read), 128'(0));
    check("abort_busywait", 128'(busywait), 128'(0));
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h184, 32'h0);
    #1 check("after_reset_remiss", 128'(busywait), 128'(1));
    @(posedge clock); #1;
    check("after_reset_no_wb", 128'({mem_read, mem_write}), 128'(2'b10));
    wait_ready("after_reset");
    check("after_reset_readdata", 128'(readdata), 128'(32'h87868584));

    // Simultaneous read and write behaves as a store
    @(posedge clock); #1;
    drive(1'b1, 1'b1, 32'h200, 32'hCAFEF00D);
    #1 check("rw_busy", 128'(busywait), 128'(1));
    wait_ready("rw");
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h200, 32'h0);
    #1 check("rw_readback", 128'(readdata), 128'(32'hCAFEF00D));
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h204, 32'h0);
    #1 check("rw_neighbour", 128'(readdata), 128'(32'h07060504));

    // The store must have dirtied the line
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h284, 32'h0);
    @(posedge clock); #1;
    check("rw_dirty_wb", 128'(mem_write), 128'(1));
    check("rw_dirty_wb_address", 128'(mem_address), 128'(28'h0000020));
    check("rw_dirty_wb_word0", 128'(mem_writedata[31:0]), 128'(32'hCAFEF00D));
    wait_ready("rw_evict");
    check("rw_evict_readdata", 128'(readdata), 128'(32'h87868584));
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;

`ifdef DCACHE_STATS_EN
    // Since the mid-miss reset: hits 0x200, 0x204; misses 0x184, 0x200, 0x284
    check("stats_hit_count", 128'(hit_count), 128'(2));
    check("stats_miss_count", 128'(miss_count), 128'(3));
`endif
    check("no_rw_overlap", 128'(overlap), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
